// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Fetch-side buffer sitting directly after the program counter. Each valid
//   cycle captures the {PC, instruction} pair into a DEPTH-entry FIFO and
//   presents the oldest entry to decode through a valid/ready handshake.
//   PCWrite back-pressures the PC while the queue is full, and Flush discards
//   every queued (wrong-path) entry.
//
// Parameters
//   DEPTH  queue entries (power of two, >= 2)
//   AW     pointer width, log2(DEPTH)
//
// Ports
//   Clk          in   rising-edge clock
//   Reset        in   asynchronous reset, active low
//   PCResult     in   [31:0] current PC
//   Instruction  in   [31:0] instruction memory data for PCResult
//   FetchValid   in   PCResult/Instruction pair valid this cycle
//   Flush        in   redirect: drop all queued entries and this cycle's pair
//   PCWrite      out  PC may advance/load this cycle
//   DecValid     out  head entry valid for decode
//   DecReady     in   decode accepts the head entry
//   DecPC        out  [31:0] PC of head entry (0 when empty)
//   DecInstr     out  [31:0] instruction of head entry (0 when empty)
//   StallCount   out  [31:0] saturating count of cycles fetch was blocked by a
//                     full queue; present only when FETCH_QUEUE_STATS_EN is
//                     defined
//
// Build option
//   FETCH_QUEUE_STATS_EN  adds the StallCount port and its counter.
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        FetchValid,
  input  logic        Flush,
  output logic        PCWrite,
  output logic        DecValid,
  input  logic        DecReady,
  output logic [31:0] DecPC,
  output logic [31:0] DecInstr
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0] StallCount
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [63:0]   storage [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg,  count_next;

  logic full, empty, push, pop;

  always_comb begin
    full  = (count_reg == DEPTH_C);
    empty = (count_reg == '0);
    // Push is gated by the registered full flag only, so a same-cycle pop
    // never frees a slot for the pair on the input: keeps DecReady out of
    // the PCWrite path.
    push  = FetchValid & ~full & ~Flush;
    pop   = ~empty & DecReady & ~Flush;

    PCWrite  = ~full | Flush;
    DecValid = ~empty;
    DecPC    = '0;
    DecInstr = '0;
    if (!empty) begin
      {DecPC, DecInstr} = storage[rd_ptr_reg];
    end

    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (Flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)      count_next = count_reg + 1'b1;
      else if (pop && !push) count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Payload storage is not reset; count/empty gate what decode sees.
  always_ff @(posedge Clk) begin
    if (push) begin
      storage[wr_ptr_reg] <= {PCResult, Instruction};
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_reg;

  // Flush does not clear the statistic; only Reset does.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_reg <= '0;
    end else if (FetchValid && full && !Flush && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign StallCount = stall_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue: directed scenarios followed by random
//   traffic, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        FetchValid;
  logic        Flush;
  logic        PCWrite;
  logic        DecValid;
  logic        DecReady;
  logic [31:0] DecPC;
  logic [31:0] DecInstr;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] StallCount;
`endif

  fetch_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PCResult    (PCResult),
    .Instruction (Instruction),
    .FetchValid  (FetchValid),
    .Flush       (Flush),
    .PCWrite     (PCWrite),
    .DecValid    (DecValid),
    .DecReady    (DecReady),
    .DecPC       (DecPC),
    .DecInstr    (DecInstr)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .StallCount  (StallCount)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: ordered list of {pc, instr} plus the stall statistic.
  logic [63:0] model_q [$];
  logic [31:0] model_stall;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic fl);
    logic [63:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 64'd0;
    check("decvalid", DecValid, model_q.size() > 0);
    check("decpc",    DecPC,    head[63:32]);
    check("decinstr", DecInstr, head[31:0]);
    check("pcwrite",  PCWrite,  (model_q.size() < DEPTH) || fl);
`ifdef FETCH_QUEUE_STATS_EN
    check("stallcount", StallCount, model_stall);
`endif
  endtask

  // Called just after a rising edge. Drives one cycle, checks mid-cycle,
  // then advances the model across the next edge.
  task automatic cycle(input logic fv, input logic [31:0] pc, input logic fl, input logic rdy);
    logic full, do_push, do_pop;
    FetchValid  = fv;
    PCResult    = pc;
    Instruction = mem_of(pc);
    Flush       = fl;
    DecReady    = rdy;
    #3;
    check_outputs(fl);
    full    = (model_q.size() == DEPTH);
    do_push = fv && !full && !fl;
    do_pop  = (model_q.size() > 0) && rdy && !fl;
    $display("cyc t=%0t fv=%0b pc=%h fl=%0b rdy=%0b push=%0b pop=%0b occ=%0d",
             $time, fv, pc, fl, rdy, do_push, do_pop, model_q.size());
    @(posedge Clk);
    #1;
    if (fv && full && !fl && model_stall != 32'hFFFF_FFFF) model_stall++;
    if (fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, mem_of(pc)});
    end
  endtask

  logic [31:0] rpc;
  logic        rfv, rfl, rrdy;

  initial begin
    Reset = 1'b0; FetchValid = 1'b0; Flush = 1'b0; DecReady = 1'b0;
    PCResult = '0; Instruction = '0;
    model_stall = '0;
    #2;
    check("reset_decvalid", DecValid, 1'b0);
    check("reset_pcwrite",  PCWrite,  1'b1);
    #10 Reset = 1'b1;
    @(posedge Clk); #1;

    // Idle, then three pushes, fourth fills, fifth/sixth blocked.
    cycle(1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'(4*i), 1'b0, 1'b0);
    // Push and pop while full: pop only.
    cycle(1'b1, 32'd20, 1'b0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);
    // Drain the rest.
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Three entries queued, then Flush with a valid pair present.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h100 + 32'(4*i), 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 1'b1, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1);

    // Ten push/pop cycles to wrap the pointers.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(4*i), 1'b0, 1'b1);

    // Random traffic.
    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      rfv  = ($urandom_range(0, 3) != 0);
      rfl  = ($urandom_range(0, 19) == 0);
      rrdy = ($urandom_range(0, 2) != 0);
      if (rfl) begin
        cycle(rfv, rpc, 1'b1, rrdy);
        rpc = {$urandom_range(0, 16'hFFFF), 2'b00};
      end else begin
        cycle(rfv, rpc, 1'b0, rrdy);
        if (rfv && model_q.size() > 0 && model_q[model_q.size()-1][63:32] == rpc)
          rpc = rpc + 32'd4;
      end
    end

    // Fill partly, then assert reset between edges: empties without a clock.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h200 + 32'(4*i), 1'b0, 1'b0);
    FetchValid = 1'b0;
    Reset = 1'b0;
    #1;
    model_q.delete();
    model_stall = '0;
    check_outputs(1'b0);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    cycle(1'b0, 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
